led_pattern: RTL
================

# led_pattern

Parametrised LED pattern generator: next generation of the single-mode 16-bit rotating light. Drives an N-bit LED bank from one clock with a programmable step prescaler and four runtime-selectable patterns: rotate left, rotate right, bounce, and PWM breathing. It sits at the board top and is the standard bring-up and stimulus block for the simulation harness. An optional compiled-in simulation stop lets the C++ harness end the run by detecting the finish.

## Interface
- `N_LED`, default 16: LED count; must be at least 2.
- `STEP_CYCLES`, default 5000: enabled clock cycles per pattern step; must be at least 1.
- `PWM_BITS`, default 8: breathing PWM resolution.
- `SIM_CYCLES`, default 100000: stop point; used only with the macro in Configuration.
- `clk` input 1: single clock; all logic samples on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: advance enable. When low, all counters and outputs hold.
- `mode` input 2: pattern select.
  - 0: rotate left.
  - 1: rotate right.
  - 2: bounce.
  - 3: breathe.
- `led` output N_LED: registered LED drive.
- `step_pulse` output 1: registered, one cycle high per pattern step.
- `mode_q` output 2: mode currently in effect.

## Operation
- Reset values:
  - `led` = 1 (bit 0 only).
  - `step_pulse` = 0.
  - `mode_q` = 0.
  - Internal state: `cnt`=0, `pos`=0, `dir`=up, `duty`=0, `pwm_cnt`=0.
- Prescaler:
  - `cnt` counts 0..STEP_CYCLES-1 on enabled cycles.
  - A step occurs on the enabled edge where `cnt`==STEP_CYCLES-1; `cnt` wraps to 0 on that edge.
  - The step period is exactly STEP_CYCLES enabled cycles.
- Mode sampling:
  - `mode` is sampled into `mode_q` only on a step edge.
  - If the sampled value differs from `mode_q`, the pattern restarts on that edge: `led`=1, `pos`=0, `dir`=up, `duty`=0.
  - The restart replaces the normal step update.
- Rotate left: each step, `led` becomes {led[N-2:0], led[N-1]}.
- Rotate right: each step, `led` becomes {led[0], led[N-1:1]}.
- Bounce:
  - `led` is one-hot at `pos`.
  - `pos` increments while `dir`=up and decrements while `dir`=down.
  - Direction reverses at the ends: at N-1 the next position is N-2; at 0 the next position is 1.
  - Sequence period is 2·N-2 steps; no end position repeats.
- Breathe:
  - `pwm_cnt` is a free-running PWM_BITS counter that advances on every enabled cycle.
  - `led` is registered as all bits equal to (`pwm_cnt` < `duty`).
  - Each step moves `duty` by one along a triangle 0 → 2^PWM_BITS-1 → 0; the direction flips at both ends with no repeated value.
  - `duty`=0 gives all LEDs off.
  - `duty`=max gives all LEDs on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Leaving breathe mode takes `led` back to 1 through the mode-change restart.
- Arithmetic: `cnt` width is $clog2(STEP_CYCLES) with a minimum of 1. All counters wrap explicitly and never overflow.

## Timing
- `step_pulse` is high in the cycle immediately after the step edge, i.e. coincident with the new `led` value.
- Latency:
  - Rotate and bounce modes: `led` changes on the step edge, 0 extra cycles.
  - Breathe mode: `led` lags `pwm_cnt`/`duty` by 1 cycle.
- With `en` low, `step_pulse` is 0 and nothing advances.
- Asserting `en` resumes from the held `cnt`; no step is lost or duplicated.
- With STEP_CYCLES=1, a step occurs on every enabled cycle and `step_pulse` stays high continuously.
- `rst` overrides `en` and `mode` on the same edge. Reset mid-pattern returns all state to the reset values in the next cycle.
- `mode` changes between step edges have no effect. Only the value present on the step edge counts.

## Configuration
- `LED_PATTERN_SIM_STOP_EN`, when defined:
  - An additional 32-bit cycle counter is built in. It is cleared by `rst` and increments on every non-reset cycle, regardless of `en`.
  - `$finish` executes on the edge where the counter equals SIM_CYCLES, for the harness's finish detection.
- When undefined: no counter and no `$finish`; the block is synthesizable as-is.

## Test plan
Tests 1–5 use N_LED=4 and STEP_CYCLES=3.
1. Reset, then `en`=1 and `mode`=0 → `led` is 0001, 0010, 0100, 1000, 0001, changing every 3 cycles; `step_pulse` is high one cycle per change.
2. `mode`=2 from reset → `led` is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 (6-step period).
3. `mode` is switched 0→1 in the middle of a step → `mode_q` updates only at the next step edge; `led` restarts at 0001 on that edge, then goes 1000, 0100.
4. `en` is dropped for 10 cycles at `cnt`=1 → `led`, `cnt` and `step_pulse` are frozen; the next step occurs 2 enabled cycles after re-enable.
5. `rst` is pulsed during bounce at `pos`=3 → the next cycle shows `led`=0001 and `step_pulse`=0; the sequence restarts 0001, 0010.
6. PWM_BITS=2, STEP_CYCLES=8, `mode`=3 → `duty` goes 0,1,2,3,2,1,0. At `duty`=1, `led` is all-ones for 1 of every 4 cycles; at `duty`=0 it is never on. With the macro defined and SIM_CYCLES=50, the run ends on cycle 50.

Source files
------------

// File: rtl/led_pattern.sv
// LED pattern generator: rotate-left/right, bounce and PWM breathe over N_LED outputs, stepped by a prescaler.
// Latency: led/step_pulse update on the step edge; breathe led lags pwm_cnt/duty by 1 cycle. No backpressure; en low freezes all state.
// Define LED_PATTERN_SIM_STOP_EN to build a cycle counter that calls $finish at SIM_CYCLES.
module led_pattern #(
    parameter int N_LED       = 16,
    parameter int STEP_CYCLES = 5000,
    parameter int PWM_BITS    = 8,
    parameter int SIM_CYCLES  = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             step_pulse,
    output logic [1:0]       mode_q
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int POS_W = $clog2(N_LED);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LED - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [N_LED-1:0]    LED_RST  = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_ROL     = 2'd0,
        MODE_ROR     = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_up_q, dir_up_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                step_pulse_q, step_pulse_d;
    logic [1:0]          mode_d;
    logic                step;

    always_comb begin
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        dir_up_d     = dir_up_q;
        duty_d       = duty_q;
        pwm_cnt_d    = pwm_cnt_q;
        led_d        = led_q;
        mode_d       = mode_q;
        step_pulse_d = 1'b0;
        step         = en && (cnt_q == CNT_LAST);

        if (en) begin
            pwm_cnt_d    = pwm_cnt_q + 1'b1;
            cnt_d        = step ? '0 : cnt_q + 1'b1;
            step_pulse_d = step;
            if (mode_q == MODE_BREATHE) begin
                led_d = {N_LED{pwm_cnt_q < duty_q}};
            end
            if (step) begin
                mode_d = mode;
                // A new mode always starts from a known pattern origin.
                if (mode != mode_q) begin
                    led_d    = LED_RST;
                    pos_d    = '0;
                    dir_up_d = 1'b1;
                    duty_d   = '0;
                end else begin
                    case (mode_q)
                        MODE_ROL: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
                        MODE_ROR: led_d = {led_q[0], led_q[N_LED-1:1]};
                        MODE_BOUNCE: begin
                            if (dir_up_q) begin
                                if (pos_q == POS_LAST) begin
                                    pos_d    = pos_q - 1'b1;
                                    dir_up_d = 1'b0;
                                end else begin
                                    pos_d = pos_q + 1'b1;
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    pos_d    = pos_q + 1'b1;
                                    dir_up_d = 1'b1;
                                end else begin
                                    pos_d = pos_q - 1'b1;
                                end
                            end
                            led_d = LED_RST << pos_d;
                        end
                        default: begin
                            if (dir_up_q) begin
                                if (duty_q == DUTY_MAX) begin
                                    duty_d   = duty_q - 1'b1;
                                    dir_up_d = 1'b0;
                                end else begin
                                    duty_d = duty_q + 1'b1;
                                end
                            end else begin
                                if (duty_q == '0) begin
                                    duty_d   = duty_q + 1'b1;
                                    dir_up_d = 1'b1;
                                end else begin
                                    duty_d = duty_q - 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            pos_q        <= '0;
            dir_up_q     <= 1'b1;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            led_q        <= LED_RST;
            step_pulse_q <= 1'b0;
            mode_q       <= MODE_ROL;
        end else begin
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            dir_up_q     <= dir_up_d;
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
            mode_q       <= mode_d;
        end
    end

    assign led        = led_q;
    assign step_pulse = step_pulse_q;

`ifdef LED_PATTERN_SIM_STOP_EN
    logic [31:0] sim_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sim_cnt_q <= '0;
        end else begin
            sim_cnt_q <= sim_cnt_q + 32'd1;
            if (sim_cnt_q == 32'(SIM_CYCLES)) begin
                $finish;
            end
        end
    end
`else
`endif

endmodule
